// File: rtl/mtm_alu_ctrl.sv
// ALU frame sequencer: collects 8 data bytes plus a command byte, validates the frame,
// runs the core and returns exactly one response per command. Stats outputs: MTM_ALU_CTRL_STATS_EN.
module mtm_alu_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 1024
`ifdef MTM_ALU_CTRL_STATS_EN
   ,
   parameter int unsigned CNT_W = 16
`endif
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic        rx_is_cmd,
   input  logic [7:0]  rx_byte,
   output logic        core_start,
   output logic [31:0] core_a,
   output logic [31:0] core_b,
   output logic [2:0]  core_op,
   input  logic        core_done,
   input  logic [31:0] core_c,
   input  logic [3:0]  core_flags,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_err,
   output logic [31:0] tx_c,
   output logic [7:0]  tx_ctl
`ifdef MTM_ALU_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0] stat_frames,
   output logic [CNT_W-1:0] stat_errors,
   output logic [CNT_W-1:0] stat_timeouts
`endif
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
   localparam int unsigned BCNT_W = 4;
   localparam logic [BCNT_W-1:0] BYTES_FULL = BCNT_W'(8);

   typedef enum logic [1:0] {S_COLLECT, S_CHECK, S_EXEC, S_SEND} state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   cnt_q, cnt_d;
   logic                data_err_q, data_err_d;
   logic [TMR_W-1:0]    timer_q, timer_d;
   logic [63:0]         data_q, data_d;
   logic [6:0]          cmd_q, cmd_d;
   logic                core_start_q, core_start_d;
   logic [31:0]         core_a_q, core_a_d;
   logic [31:0]         core_b_q, core_b_d;
   logic [2:0]          core_op_q, core_op_d;
   logic                tx_valid_q, tx_valid_d;
   logic                tx_err_q, tx_err_d;
   logic [31:0]         tx_c_q, tx_c_d;
   logic [7:0]          tx_ctl_q, tx_ctl_d;

   logic err_data, err_crc, err_op, ctl_par;
   logic tmo_hit, resp_acc;

   // CRC4, poly x^4+x+1, init 0, MSB first
   function automatic logic [3:0] crc4(input logic [67:0] m);
      logic [3:0] c;
      logic       fb;
      c = '0;
      for (int i = 67; i >= 0; i--) begin
         fb = c[3] ^ m[i];
         c  = {c[2:0], 1'b0} ^ {2'b00, fb, fb};
      end
      return c;
   endfunction

   // CRC3, poly x^3+x+1, init 0, MSB first
   function automatic logic [2:0] crc3(input logic [36:0] m);
      logic [2:0] c;
      logic       fb;
      c = '0;
      for (int i = 36; i >= 0; i--) begin
         fb = c[2] ^ m[i];
         c  = {c[1:0], 1'b0} ^ {1'b0, fb, fb};
      end
      return c;
   endfunction

   // Frame checks; data_q holds {B, A} once eight bytes have arrived
   always_comb begin
      err_data = data_err_q || (cnt_q != BYTES_FULL);
      err_crc  = !err_data && (crc4({data_q, 1'b1, cmd_q[6:4]}) != cmd_q[3:0]);
      err_op   = !err_data && !err_crc &&
                 !(cmd_q[6:4] inside {3'b000, 3'b001, 3'b100, 3'b101});
      ctl_par  = ^{1'b1, err_data, err_crc, err_op, err_data, err_crc, err_op};
   end

   assign tmo_hit  = (state_q == S_COLLECT) && !rx_valid && (cnt_q != '0) &&
                     (timer_q == TMR_W'(TIMEOUT_CYC - 1));
   assign resp_acc = (state_q == S_SEND) && tx_ready;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_err_d   = data_err_q;
      timer_d      = timer_q;
      data_d       = data_q;
      cmd_d        = cmd_q;
      core_start_d = 1'b0;
      core_a_d     = core_a_q;
      core_b_d     = core_b_q;
      core_op_d    = core_op_q;
      tx_valid_d   = tx_valid_q;
      tx_err_d     = tx_err_q;
      tx_c_d       = tx_c_q;
      tx_ctl_d     = tx_ctl_q;
      case (state_q)
         S_COLLECT: begin
            if (rx_valid) begin
               timer_d = '0;
               if (rx_is_cmd) begin
                  cmd_d   = rx_byte[6:0];
                  state_d = S_CHECK;
               end else if (cnt_q < BYTES_FULL) begin
                  data_d = {data_q[55:0], rx_byte};
                  cnt_d  = cnt_q + BCNT_W'(1);
               end else begin
                  data_err_d = 1'b1;
               end
            end else if (tmo_hit) begin
               cnt_d      = '0;
               data_err_d = 1'b0;
               timer_d    = '0;
            end else if (cnt_q != '0) begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_CHECK: begin
            if (err_data || err_crc || err_op) begin
               tx_err_d   = 1'b1;
               tx_c_d     = '0;
               tx_ctl_d   = {1'b1, err_data, err_crc, err_op,
                             err_data, err_crc, err_op, ctl_par};
               tx_valid_d = 1'b1;
               state_d    = S_SEND;
            end else begin
               core_b_d     = data_q[63:32];
               core_a_d     = data_q[31:0];
               core_op_d    = cmd_q[6:4];
               core_start_d = 1'b1;
               state_d      = S_EXEC;
            end
         end
         S_EXEC: begin
            if (core_done) begin
               tx_c_d     = core_c;
               tx_ctl_d   = {1'b0, core_flags, crc3({core_c, 1'b0, core_flags})};
               tx_err_d   = 1'b0;
               tx_valid_d = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (resp_acc) begin
               tx_valid_d = 1'b0;
               cnt_d      = '0;
               data_err_d = 1'b0;
               state_d    = S_COLLECT;
            end
         end
         default: state_d = S_COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_COLLECT;
         cnt_q        <= '0;
         data_err_q   <= 1'b0;
         timer_q      <= '0;
         data_q       <= '0;
         cmd_q        <= '0;
         core_start_q <= 1'b0;
         core_a_q     <= '0;
         core_b_q     <= '0;
         core_op_q    <= '0;
         tx_valid_q   <= 1'b0;
         tx_err_q     <= 1'b0;
         tx_c_q       <= '0;
         tx_ctl_q     <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_err_q   <= data_err_d;
         timer_q      <= timer_d;
         data_q       <= data_d;
         cmd_q        <= cmd_d;
         core_start_q <= core_start_d;
         core_a_q     <= core_a_d;
         core_b_q     <= core_b_d;
         core_op_q    <= core_op_d;
         tx_valid_q   <= tx_valid_d;
         tx_err_q     <= tx_err_d;
         tx_c_q       <= tx_c_d;
         tx_ctl_q     <= tx_ctl_d;
      end
   end

   assign core_start = core_start_q;
   assign core_a     = core_a_q;
   assign core_b     = core_b_q;
   assign core_op    = core_op_q;
   assign tx_valid   = tx_valid_q;
   assign tx_err     = tx_err_q;
   assign tx_c       = tx_c_q;
   assign tx_ctl     = tx_ctl_q;

`ifdef MTM_ALU_CTRL_STATS_EN
   logic [CNT_W-1:0] stat_frames_q, stat_frames_d;
   logic [CNT_W-1:0] stat_errors_q, stat_errors_d;
   logic [CNT_W-1:0] stat_timeouts_q, stat_timeouts_d;

   // Saturating event counters
   always_comb begin
      stat_frames_d   = stat_frames_q;
      stat_errors_d   = stat_errors_q;
      stat_timeouts_d = stat_timeouts_q;
      if (resp_acc && (stat_frames_q != '1))
         stat_frames_d = stat_frames_q + CNT_W'(1);
      if (resp_acc && tx_err_q && (stat_errors_q != '1))
         stat_errors_d = stat_errors_q + CNT_W'(1);
      if (tmo_hit && (stat_timeouts_q != '1))
         stat_timeouts_d = stat_timeouts_q + CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_frames_q   <= '0;
         stat_errors_q   <= '0;
         stat_timeouts_q <= '0;
      end else begin
         stat_frames_q   <= stat_frames_d;
         stat_errors_q   <= stat_errors_d;
         stat_timeouts_q <= stat_timeouts_d;
      end
   end

   assign stat_frames   = stat_frames_q;
   assign stat_errors   = stat_errors_q;
   assign stat_timeouts = stat_timeouts_q;
`endif

endmodule
